// File: rtl/mips_pkg.sv
// Shared memory-interface constants and the fetch FIFO entry type.
package mips_pkg;

  localparam logic [1:0]  SZ_BYTE  = 2'd0;
  localparam logic [1:0]  SZ_WORD  = 2'd1;
  localparam logic [1:0]  SZ_4WORD = 2'd2;
  localparam logic [1:0]  SZ_8WORD = 2'd3;

  localparam logic [31:0] MEM_BASE = 32'h8002_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries: power-of-two depth, synchronous flush,
// async active-low reset of pointers and count.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_data,
  output fetch_entry_t     o_head,
  output logic [CNT_W-1:0] o_count
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;

  assign w_full = (r_count == CNT_W'(DEPTH));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; a slot is only read
  // after it has been written, so reset would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // The issue rule upstream reserves a slot for every outstanding request.
  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!rst_n) !(i_push && w_full)
  );

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-word reads, prefetch FIFO, redirect flush.
// Optional performance counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = MEM_BASE,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_access_size,
  output logic        mem_rd_wr,
  output logic        mem_enable,
  input  logic [31:0] mem_data_out,
  input  logic        mem_busy,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      r_pc;
  logic [31:0]      r_tag;
  logic             r_pending;
  logic             r_fetch_err;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occupancy;
  fetch_entry_t     w_head;
  fetch_entry_t     w_entry;
  logic             w_push;
  logic             w_pop;
  logic             w_issue;

  assign w_pop = if_valid && if_ready;

  // A slot freed by this cycle's handshake may be reused by this cycle's issue;
  // that is what sustains one instruction per cycle with two entries.
  assign w_occupancy = {1'b0, w_count} - (CNT_W+1)'(w_pop) + (CNT_W+1)'(r_pending);
  assign w_issue     = reset_n && !redirect && !mem_busy &&
                       (w_occupancy < (CNT_W+1)'(DEPTH));

  // A redirect on the capture edge drops the returning word.
  assign w_push  = r_pending && !redirect;
  assign w_entry = '{instr: mem_data_out, pc: r_tag};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc        <= RESET_PC;
      r_tag       <= '0;
      r_pending   <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      if (redirect)     r_pc <= word_align(redirect_pc);
      else if (w_issue) r_pc <= r_pc + 32'd4;
      if (w_issue)      r_tag <= r_pc;
      r_pending <= w_issue;
      if (redirect && (redirect_pc[1:0] != 2'b00)) r_fetch_err <= 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign mem_addr        = r_pc;
  assign mem_data_in     = 32'h0;
  assign mem_access_size = SZ_WORD;
  assign mem_rd_wr       = 1'b1;
  assign mem_enable      = w_issue;

  assign if_valid  = (w_count != '0);
  assign if_instr  = if_valid ? w_head.instr : 32'h0;
  assign if_pc     = if_valid ? w_head.pc    : 32'h0;
  assign fetch_err = r_fetch_err;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_fetch_cnt <= '0;
    else if (w_pop) r_fetch_cnt <= r_fetch_cnt + 32'd1;
  end

  assign fetch_cnt = r_fetch_cnt;
`else
  assign fetch_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector tables for start-up,
// plus a handshake scoreboard across stall, redirect, busy and reset sequences.
module tb_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] B = 32'h8002_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_rd_wr;
  logic        mem_enable;
  logic [31:0] mem_data_out;
  logic        mem_busy;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  fetch_unit #(.RESET_PC(B), .DEPTH(2)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_addr        (mem_addr),
    .mem_data_in     (mem_data_in),
    .mem_access_size (mem_access_size),
    .mem_rd_wr       (mem_rd_wr),
    .mem_enable      (mem_enable),
    .mem_data_out    (mem_data_out),
    .mem_busy        (mem_busy),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .fetch_err       (fetch_err),
    .fetch_cnt       (fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int hs_cnt  = 0;

  function automatic logic [31:0] instr_for(input logic [31:0] a);
    case (a)
      B:          return 32'h0000_0011;
      B + 32'd4:  return 32'h0000_0022;
      B + 32'd8:  return 32'h0000_0033;
      default:    return {a[15:0], 16'hC0DE};
    endcase
  endfunction

  // Memory model: word registered at the issue edge, poison otherwise.
  always @(posedge clk) begin
    if (mem_enable) mem_data_out <= instr_for(mem_addr);
    else            mem_data_out <= 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  fetch_entry_t sb_q[$];
  fetch_entry_t mon_e;

  task automatic sb_push_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = start + 32'(4 * i);
      sb_q.push_back('{instr: instr_for(a), pc: a});
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && if_valid && if_ready) begin
      hs_cnt++;
      if (sb_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL sb_extra: unexpected delivery pc=%h instr=%h", if_pc, if_instr);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_pc", if_pc, mon_e.pc);
        check("sb_instr", if_instr, mon_e.instr);
      end
    end
  end

  typedef struct {
    logic        rdy;
    logic        en;
    logic        vld;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t tab_run[6];
  vec_t tab_stall[5];

  task automatic apply_vec(input string tag, input vec_t v);
    if_ready = v.rdy;
    @(negedge clk);
    check({tag, "_mem_enable"}, 32'(mem_enable), 32'(v.en));
    check({tag, "_mem_addr"},   mem_addr,        v.addr);
    check({tag, "_if_valid"},   32'(if_valid),   32'(v.vld));
    check({tag, "_if_pc"},      if_pc,           v.pc);
    check({tag, "_if_instr"},   if_instr,        v.instr);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input string tag, input int target, input int budget);
    int n = 0;
    while (hs_cnt < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_handshakes"}, 32'(hs_cnt), 32'(target));
  endtask

  initial begin
    int hs_base;
    int n;

    //                rdy   en    vld   addr         pc          instr
    tab_run[0]   = '{1'b1, 1'b1, 1'b0, B,           32'h0,      32'h0};
    tab_run[1]   = '{1'b1, 1'b1, 1'b0, B + 32'h4,   32'h0,      32'h0};
    tab_run[2]   = '{1'b1, 1'b1, 1'b1, B + 32'h8,   B,          32'h11};
    tab_run[3]   = '{1'b1, 1'b1, 1'b1, B + 32'hC,   B + 32'h4,  32'h22};
    tab_run[4]   = '{1'b1, 1'b1, 1'b1, B + 32'h10,  B + 32'h8,  32'h33};
    tab_run[5]   = '{1'b1, 1'b1, 1'b1, B + 32'h14,  B + 32'hC,  instr_for(B + 32'hC)};
    tab_stall[0] = '{1'b0, 1'b1, 1'b0, B,           32'h0,      32'h0};
    tab_stall[1] = '{1'b0, 1'b1, 1'b0, B + 32'h4,   32'h0,      32'h0};
    tab_stall[2] = '{1'b0, 1'b0, 1'b1, B + 32'h8,   B,          32'h11};
    tab_stall[3] = '{1'b0, 1'b0, 1'b1, B + 32'h8,   B,          32'h11};
    tab_stall[4] = '{1'b0, 1'b0, 1'b1, B + 32'h8,   B,          32'h11};

    reset_n     = 1'b0;
    if_ready    = 1'b0;
    mem_busy    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset state and constant outputs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_enable", 32'(mem_enable), 32'd0);
    check("rst_if_valid",   32'(if_valid),   32'd0);
    check("rst_if_instr",   if_instr,        32'h0);
    check("rst_if_pc",      if_pc,           32'h0);
    check("rst_fetch_err",  32'(fetch_err),  32'd0);
    check("rst_fetch_cnt",  fetch_cnt,       32'h0);
    check("rst_mem_addr",   mem_addr,        B);
    check("rst_rd_wr",      32'(mem_rd_wr),  32'd1);
    check("rst_size",       32'(mem_access_size), 32'(SZ_WORD));
    check("rst_data_in",    mem_data_in,     32'h0);

    // Start-up with decode always ready.
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb_push_run(B, 4);
    for (int i = 0; i < 6; i++) apply_vec($sformatf("run[%0d]", i), tab_run[i]);
    check("run_sb_drained", 32'(sb_q.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("run_fetch_cnt", fetch_cnt, 32'd4);
`else
    check("run_fetch_cnt_off", fetch_cnt, 32'h0);
`endif

    // Asynchronous reset between edges, mid-stream.
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_mem_enable", 32'(mem_enable), 32'd0);
    check("arst_if_valid",   32'(if_valid),   32'd0);
    check("arst_if_instr",   if_instr,        32'h0);
    check("arst_if_pc",      if_pc,           32'h0);
    check("arst_mem_addr",   mem_addr,        B);
    check("arst_fetch_cnt",  fetch_cnt,       32'h0);
    sb_q.delete();
    hs_cnt = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Decode stalled for five cycles from restart, then released.
    for (int i = 0; i < 5; i++) apply_vec($sformatf("stall[%0d]", i), tab_stall[i]);
    sb_push_run(B, 10);
    if_ready = 1'b1;
    wait_hs("resume", 10, 40);
`ifdef FETCH_PERF_CNT_EN
    check("cnt_after_10", fetch_cnt, 32'd10);
`else
    check("cnt_off_after_10", fetch_cnt, 32'h0);
`endif
    check("resume_sb_drained", 32'(sb_q.size()), 32'd0);

    // Aligned redirect while a FIFO entry and a request are outstanding.
    if_ready    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = B + 32'h40;
    sb_push_run(B + 32'h40, 5);
    @(negedge clk);
    check("redir_pre_valid", 32'(if_valid),   32'd1);
    check("redir_no_issue",  32'(mem_enable), 32'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    if_ready = 1'b1;
    @(negedge clk);
    check("redir_post_valid", 32'(if_valid),   32'd0);
    check("redir_post_en",    32'(mem_enable), 32'd1);
    check("redir_post_addr",  mem_addr,        B + 32'h40);
    @(posedge clk);
    #1;
    hs_base = hs_cnt;
    wait_hs("redir_stream", hs_base + 4, 20);

    // Misaligned redirect in the same cycle as a handshake.
    redirect    = 1'b1;
    redirect_pc = B + 32'h46;
    sb_push_run(B + 32'h44, 12);
    @(negedge clk);
    check("mis_pre_valid", 32'(if_valid),  32'd1);
    check("mis_pre_err",   32'(fetch_err), 32'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    check("mis_err_set", 32'(fetch_err), 32'd1);
    @(negedge clk);
    check("mis_post_valid", 32'(if_valid), 32'd0);
    check("mis_post_addr",  mem_addr,      B + 32'h44);
    @(posedge clk);
    #1;
    hs_base = hs_cnt;
    wait_hs("mis_stream", hs_base + 4, 20);

    // Memory busy for three cycles in a steady stream.
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("busy[%0d]_en", i),   32'(mem_enable), 32'd0);
      check($sformatf("busy[%0d]_addr", i), mem_addr,        B + 32'h5C);
      @(posedge clk);
      #1;
    end
    mem_busy = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if_ready = 1'b0;
    check("busy_sb_drained", 32'(sb_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", 32'(fetch_err), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("cnt_final", fetch_cnt, 32'(hs_cnt));
`else
    check("cnt_final_off", fetch_cnt, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
